pwm_duty_sequencer: RTL and testbench

Controller that owns the duty-cycle register feeding the PWM generator (servo/LED, 50 Hz frame at 50 MHz).
- Accepts debounced inc/dec requests (manual mode) or autonomously sweeps duty between MIN_DC and MAX_DC (auto mode).
- Commits new duty values only at PWM period boundaries, so the generator never sees a mid-period change.
- Sits between the debouncers and the PWM counter/comparator.

---
 rtl/pwm_duty_sequencer.sv | 131 +++++++++++++
 tb/tb_pwm_duty_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_sequencer.sv
// Duty-cycle sequencer for a PWM generator: manual inc/dec or automatic sweep
// between MIN_DC and MAX_DC, with new values committed only at period boundaries.
module pwm_duty_sequencer #(
  parameter int          W      = 32,
  parameter int unsigned COUNTS = 1_000_000,
  parameter int unsigned STEP   = 100_000,
  parameter int unsigned MIN_DC = 50_000,
  parameter int unsigned MAX_DC = 100_000,
  parameter int unsigned DWELL  = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_pulse,
  input  logic         dec_pulse,
  input  logic         mode_auto,
  input  logic         start,
  input  logic         period_end,
  output logic [W-1:0] duty,
  output logic         duty_valid,
  output logic         at_max,
  output logic         at_min,
  output logic [1:0]   state
);

  typedef enum logic [1:0] {
    S_MANUAL = 2'd0,
    S_UP     = 2'd1,
    S_DOWN   = 2'd2
  } state_e;

  // Upper limit never exceeds a full period, so duty can never outrun the counter.
  localparam int unsigned MAX_LIM = (MAX_DC > COUNTS) ? COUNTS : MAX_DC;

  localparam logic [W:0]   STEP_X     = (W+1)'(STEP);
  localparam logic [W:0]   MIN_X      = (W+1)'(MIN_DC);
  localparam logic [W:0]   MAX_X      = (W+1)'(MAX_LIM);
  localparam logic [W-1:0] STEP_V     = W'(STEP);
  localparam logic [W-1:0] MIN_V      = W'(MIN_DC);
  localparam logic [W-1:0] MAX_V      = W'(MAX_LIM);
  localparam logic [W-1:0] DWELL_LAST = W'(DWELL - 1);
  localparam logic [W-1:0] ONE_V      = W'(1);

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    logic [W:0] s;
    s = {1'b0, v} + STEP_X;
    if (s >= MAX_X) sat_inc = MAX_V;
    else            sat_inc = s[W-1:0];
  endfunction

  function automatic logic [W-1:0] sat_dec(input logic [W-1:0] v);
    if ({1'b0, v} <= MIN_X + STEP_X) sat_dec = MIN_V;
    else                             sat_dec = v - STEP_V;
  endfunction

  state_e       state_q, state_d;
  logic [W-1:0] pending_q, pending_d;
  logic [W-1:0] duty_q, duty_d;
  logic [W-1:0] dwell_q, dwell_d;
  logic         valid_q, valid_d;
  logic [W-1:0] stepped;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    duty_d    = duty_q;
    dwell_d   = dwell_q;
    valid_d   = 1'b0;
    stepped   = pending_q;

    // Commit uses the pending value registered before this edge.
    if (period_end) begin
      duty_d  = pending_q;
      valid_d = (pending_q != duty_q);
    end

    case (state_q)
      S_MANUAL: begin
        if (inc_pulse && !dec_pulse)      pending_d = sat_inc(pending_q);
        else if (dec_pulse && !inc_pulse) pending_d = sat_dec(pending_q);
        if (start && mode_auto) begin
          state_d = (pending_q == MAX_V) ? S_DOWN : S_UP;
          dwell_d = '0;
        end
      end
      S_UP, S_DOWN: begin
        if (!mode_auto) begin
          state_d = S_MANUAL;
          dwell_d = '0;
        end else if (period_end) begin
          if (dwell_q == DWELL_LAST) begin
            dwell_d = '0;
            if (state_q == S_UP) begin
              stepped = sat_inc(pending_q);
              if (stepped == MAX_V) state_d = S_DOWN;
            end else begin
              stepped = sat_dec(pending_q);
              if (stepped == MIN_V) state_d = S_UP;
            end
            pending_d = stepped;
          end else begin
            dwell_d = dwell_q + ONE_V;
          end
        end
      end
      default: state_d = S_MANUAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_MANUAL;
      pending_q <= MIN_V;
      duty_q    <= MIN_V;
      dwell_q   <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      duty_q    <= duty_d;
      dwell_q   <= dwell_d;
      valid_q   <= valid_d;
    end
  end

  assign duty       = duty_q;
  assign duty_valid = valid_q;
  assign at_max     = (pending_q == MAX_V);
  assign at_min     = (pending_q == MIN_V);
  assign state      = state_q;

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Scoreboard bench for pwm_duty_sequencer: a behavioural model queues each expected
// committed duty value; a monitor pops and compares on every duty_valid pulse.
module tb_pwm_duty_sequencer;
  localparam int W      = 32;
  localparam int COUNTS = 100;
  localparam int STEP   = 10;
  localparam int MIN_DC = 20;
  localparam int MAX_DC = 60;
  localparam int DWELL  = 2;
  localparam int GAP    = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         inc_pulse = 1'b0, dec_pulse = 1'b0, mode_auto = 1'b0;
  logic         start = 1'b0, period_end = 1'b0;
  logic [W-1:0] duty;
  logic         duty_valid, at_max, at_min;
  logic [1:0]   state;

  pwm_duty_sequencer #(
    .W(W), .COUNTS(COUNTS), .STEP(STEP), .MIN_DC(MIN_DC), .MAX_DC(MAX_DC), .DWELL(DWELL)
  ) dut (
    .clk(clk), .rst(rst), .inc_pulse(inc_pulse), .dec_pulse(dec_pulse),
    .mode_auto(mode_auto), .start(start), .period_end(period_end),
    .duty(duty), .duty_valid(duty_valid), .at_max(at_max), .at_min(at_min), .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int sb[$];
  int m_pend, m_duty, m_state, m_dwell;
  bit ma = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int m_inc(int v);
    return (v + STEP >= MAX_DC) ? MAX_DC : v + STEP;
  endfunction

  function automatic int m_dec(int v);
    return (v - STEP <= MIN_DC) ? MIN_DC : v - STEP;
  endfunction

  // Reference behaviour for one clock edge with the given inputs.
  function automatic void model(bit i, bit d, bit s, bit p, bit rn);
    int np;
    if (!rn) begin
      m_pend = MIN_DC; m_duty = MIN_DC; m_state = 0; m_dwell = 0;
      return;
    end
    np = m_pend;
    if (p) begin
      if (m_duty != m_pend) sb.push_back(m_pend);
      m_duty = m_pend;
    end
    if (m_state == 0) begin
      if (i && !d)      np = m_inc(m_pend);
      else if (d && !i) np = m_dec(m_pend);
      if (s && ma) begin
        m_state = (m_pend == MAX_DC) ? 2 : 1;
        m_dwell = 0;
      end
    end else if (!ma) begin
      m_state = 0;
      m_dwell = 0;
    end else if (p) begin
      if (m_dwell == DWELL - 1) begin
        m_dwell = 0;
        if (m_state == 1) begin
          np = m_inc(m_pend);
          if (np == MAX_DC) m_state = 2;
        end else begin
          np = m_dec(m_pend);
          if (np == MIN_DC) m_state = 1;
        end
      end else begin
        m_dwell++;
      end
    end
    m_pend = np;
  endfunction

  task automatic step(input bit i, input bit d, input bit s, input bit p);
    inc_pulse = i; dec_pulse = d; start = s; period_end = p; mode_auto = ma;
    model(i, d, s, p, rst);
    @(posedge clk); #1;
    inc_pulse = 1'b0; dec_pulse = 1'b0; start = 1'b0; period_end = 1'b0;
    chk("duty", duty, m_duty);
    chk("state", state, m_state);
    chk("at_max", at_max, (m_pend == MAX_DC));
    chk("at_min", at_min, (m_pend == MIN_DC));
    if (p) begin
      @(negedge clk); #1;
      chk("vld_missing", sb.size(), 0);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pe();
    idle(GAP);
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  always @(negedge clk) begin
    if (duty_valid === 1'b1) begin
      if (sb.size() == 0) chk("vld_spurious", duty_valid, 1'b0);
      else                chk("vld_duty", duty, sb.pop_front());
    end
  end

  int exp_duty[17] = '{20, 20, 30, 30, 40, 40, 50, 50, 60, 60, 50, 50, 40, 40, 30, 30, 20};
  int exp_state[17] = '{1, 1, 1, 1, 1, 1, 1, 2, 2, 2, 2, 2, 2, 2, 2, 1, 1};

  initial begin
    // Reset
    rst = 1'b0;
    idle(3);
    chk("rst_duty", duty, 20);
    chk("rst_state", state, 0);
    chk("rst_valid", duty_valid, 0);
    chk("rst_at_min", at_min, 1);
    chk("rst_at_max", at_max, 0);
    rst = 1'b1;

    // Manual stepping and clamp
    repeat (3) begin step(1, 0, 0, 0); step(0, 0, 0, 0); end
    pe();
    chk("man_duty50", duty, 50);
    chk("man_vld_hi", duty_valid, 1);
    step(0, 0, 0, 0);
    chk("man_vld_lo", duty_valid, 0);
    repeat (2) step(1, 0, 0, 0);
    pe();
    chk("man_duty60", duty, 60);
    chk("man_at_max", at_max, 1);
    step(1, 0, 0, 0);
    chk("man_clamp60", at_max, 1);
    pe();
    chk("man_no_vld", duty_valid, 0);

    // Conflicts and floor clamp
    step(1, 1, 0, 0);
    chk("both_hold", at_max, 1);
    repeat (5) step(0, 1, 0, 0);
    chk("floor_at_min", at_min, 1);
    pe();
    chk("floor_duty", duty, 20);
    step(1, 1, 0, 0);
    step(1, 0, 0, 1);
    chk("coinc_now", duty, 20);
    pe();
    chk("coinc_next", duty, 30);
    step(0, 1, 0, 0);
    pe();

    // Auto sweep with ignored manual pulses
    ma = 1'b1;
    step(0, 0, 1, 0);
    chk("auto_up", state, 1);
    for (int k = 0; k < 17; k++) begin
      step(1, 0, 0, 0);
      step(0, 1, 0, 0);
      pe();
      chk($sformatf("sweep_duty_pe%0d", k + 1), duty, exp_duty[k]);
      chk($sformatf("sweep_state_pe%0d", k + 1), state, exp_state[k]);
    end

    // Mode drop mid-sweep
    repeat (4) pe();
    chk("drop_duty40", duty, 40);
    ma = 1'b0;
    step(0, 0, 0, 0);
    chk("drop_state", state, 0);
    chk("drop_keep", duty, 40);
    step(1, 0, 0, 0);
    pe();
    chk("drop_inc50", duty, 50);

    // Reset mid-sweep
    ma = 1'b1;
    step(0, 0, 1, 0);
    repeat (5) pe();
    chk("mid_duty50", duty, 50);
    chk("mid_state2", state, 2);
    rst = 1'b0;
    step(0, 0, 0, 0);
    rst = 1'b1;
    chk("mid_rst_duty", duty, 20);
    chk("mid_rst_state", state, 0);
    step(0, 0, 1, 0);
    chk("resume_up", state, 1);
    repeat (3) pe();
    chk("resume_duty30", duty, 30);

    idle(2);
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
